mau_resp: RTL and testbench

MAU_RESP -- requirements
Module: mau_resp

---
 rtl/mau_pkg.sv | 22 ++
 rtl/mau_line_asm.sv | 45 ++++
 rtl/mau_resp.sv | 184 ++++++++++++++++++
 tb/tb_mau_resp.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// mau_pkg: FSM state encoding and beat-count helpers shared by mau_resp and mau_line_asm.
package mau_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RDNC,
    S_FILL,
    S_ACK
  } mau_state_e;

  // Number of 32-bit memory beats in one cache line.
  function automatic int mau_beats(input int line_w);
    return line_w / 32;
  endfunction

  // Width of a beat counter for one cache line.
  function automatic int mau_beat_cw(input int line_w);
    return $clog2(line_w / 32);
  endfunction

endpackage

// File: rtl/mau_line_asm.sv
// mau_line_asm: assembles the fill line (or places the NC read word at the top
// of the line) from in-order memory responses. The line register is cleared at
// request capture so NC reads return zeros in the unused bits.
module mau_line_asm
  import mau_pkg::*;
#(
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              rsp_acc,
  input  logic              nc,
  input  logic [31:0]       rsp_data,
  output logic              last,
  output logic [LINE_W-1:0] line
);

  localparam int NB = mau_beats(LINE_W);
  localparam int CW = mau_beat_cw(LINE_W);
  localparam logic [CW-1:0] LAST_BEAT = CW'(NB - 1);

  logic [CW-1:0] rsp_cnt;

  assign last = (rsp_cnt == LAST_BEAT);

  // Response counter and line register; fill words land in ascending order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_cnt <= '0;
      line    <= '0;
    end else if (clr) begin
      rsp_cnt <= '0;
      line    <= '0;
    end else if (rsp_acc) begin
      if (nc) begin
        line[LINE_W-1 -: 32] <= rsp_data;
      end else begin
        line[{rsp_cnt, 5'b0} +: 32] <= rsp_data;
        rsp_cnt <= last ? '0 : rsp_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mau_resp.sv
// mau_resp: memory access unit response path. Takes one cache-side request at a
// time (write, non-cacheable read, or line fill), runs it against a 32-bit
// memory port, and returns a single-cycle ack with the result.
// Optional: define MAU_RESP_POSTED_WR_EN to post writes into a one-entry buffer
// that drains in the background; reads wait behind a full buffer.
module mau_resp
  import mau_pkg::*;
#(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mau_req_val,
  input  logic              mau_req_nc,
  input  logic              mau_req_we,
  input  logic [ADDR_W-1:0] mau_req_addr,
  input  logic [31:0]       mau_req_wdata,
  input  logic [3:0]        mau_req_be,
  output logic              mau_req_ack,
  output logic              mau_ack_nc,
  output logic              mau_ack_we,
  output logic [LINE_W-1:0] mau_ack_data,
  output logic              mem_req_val,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  output logic [3:0]        mem_req_be,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_val,
  input  logic [31:0]       mem_rsp_data
);

  localparam int NB = mau_beats(LINE_W);
  localparam int CW = mau_beat_cw(LINE_W);
  localparam int OB = $clog2(LINE_W / 8);
  localparam logic [CW-1:0] LAST_BEAT = CW'(NB - 1);

  typedef struct packed {
    logic              nc;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        be;
  } mau_req_t;

  mau_state_e state, nxt;
  mau_req_t   cap;

  logic [CW-1:0] iss_cnt;
  logic          iss_done;
  logic [CW:0]   outst;
  logic          capture, rd_val, rd_fire, wr_fire, wr_go, rsp_acc, last;
  logic          wr_val;
  logic [ADDR_W-1:0] wr_addr, rd_addr, line_base;
  logic [31:0]   wr_data;
  logic [3:0]    wr_be;

  assign capture   = (state == S_IDLE) && mau_req_val;
  assign rd_val    = ((state == S_RDNC) || (state == S_FILL)) && !iss_done;
  assign line_base = {cap.addr[ADDR_W-1:OB], {OB{1'b0}}};
  assign rd_addr   = (state == S_RDNC) ? cap.addr
                                       : line_base + ADDR_W'({iss_cnt, 2'b00});
  // Responses only count while a read is in flight; strays are dropped.
  assign rsp_acc   = mem_rsp_val && (outst != '0);

`ifdef MAU_RESP_POSTED_WR_EN
  logic              wb_val;
  logic [ADDR_W-1:0] wb_addr;
  logic [31:0]       wb_data;
  logic [3:0]        wb_be;

  assign wr_val  = wb_val;
  assign wr_addr = wb_addr;
  assign wr_data = wb_data;
  assign wr_be   = wb_be;
  assign wr_go   = !wb_val;

  // One-entry posted write buffer; loads from WR once empty, drains on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_val  <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      wb_be   <= '0;
    end else begin
      if (wr_fire) wb_val <= 1'b0;
      if ((state == S_WR) && !wb_val) begin
        wb_val  <= 1'b1;
        wb_addr <= cap.addr;
        wb_data <= cap.wdata;
        wb_be   <= cap.be;
      end
    end
  end
`else
  assign wr_val  = (state == S_WR);
  assign wr_addr = cap.addr;
  assign wr_data = cap.wdata;
  assign wr_be   = cap.be;
  assign wr_go   = wr_fire;
`endif

  // Pending write owns the port so memory sees requests in capture order.
  assign mem_req_val   = wr_val || rd_val;
  assign mem_req_we    = wr_val;
  assign mem_req_addr  = wr_val ? wr_addr : rd_addr;
  assign mem_req_wdata = wr_data;
  assign mem_req_be    = wr_val ? wr_be : 4'hF;
  assign wr_fire       = wr_val && mem_req_ready;
  assign rd_fire       = rd_val && !wr_val && mem_req_ready;

  assign mau_req_ack = (state == S_ACK);
  assign mau_ack_nc  = cap.nc;
  assign mau_ack_we  = cap.we;

  // State and captured-request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cap   <= '0;
    end else begin
      state <= nxt;
      if (capture) cap <= '{nc: mau_req_nc, we: mau_req_we, addr: mau_req_addr,
                             wdata: mau_req_wdata, be: mau_req_be};
    end
  end

  // Next-state: fill leaves on the last response, NC read on its only one.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (mau_req_val) nxt = mau_req_we ? S_WR : (mau_req_nc ? S_RDNC : S_FILL);
      S_WR:   if (wr_go) nxt = S_ACK;
      S_RDNC: if (rsp_acc) nxt = S_ACK;
      S_FILL: if (rsp_acc && last) nxt = S_ACK;
      S_ACK:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Issue counter runs ahead of responses; outst tracks reads in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_cnt  <= '0;
      iss_done <= 1'b0;
      outst    <= '0;
    end else begin
      if (state == S_IDLE) begin
        iss_cnt  <= '0;
        iss_done <= 1'b0;
      end else if (rd_fire) begin
        if ((state == S_RDNC) || (iss_cnt == LAST_BEAT)) begin
          iss_cnt  <= '0;
          iss_done <= 1'b1;
        end else begin
          iss_cnt <= iss_cnt + CW'(1);
        end
      end
      case ({rd_fire, rsp_acc})
        2'b10:   outst <= outst + (CW+1)'(1);
        2'b01:   outst <= outst - (CW+1)'(1);
        default: outst <= outst;
      endcase
    end
  end

  mau_line_asm #(.LINE_W(LINE_W)) u_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (capture),
    .rsp_acc  (rsp_acc),
    .nc       (cap.nc),
    .rsp_data (mem_rsp_data),
    .last     (last),
    .line     (mau_ack_data)
  );

  // A response with nothing outstanding is a protocol error upstream.
  stray_rsp_a: assert property (@(posedge clk) disable iff (!rst_n)
                                !(mem_rsp_val && (outst == '0)))
    else $error("mau_resp: memory response with no read outstanding");

endmodule

// File: tb/tb_mau_resp.sv
// tb_mau_resp: directed bench for mau_resp (LINE_W=128). A queue-based memory
// model with 2-cycle read latency serves requests; expected beats and acks are
// derived from the request alone and checked every cycle.
module tb_mau_resp;

  localparam int LW = 128;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mau_req_val = 1'b0, mau_req_nc = 1'b0, mau_req_we = 1'b0;
  logic [AW-1:0] mau_req_addr = '0;
  logic [31:0]   mau_req_wdata = '0;
  logic [3:0]    mau_req_be = '0;
  logic          mau_req_ack, mau_ack_nc, mau_ack_we;
  logic [LW-1:0] mau_ack_data;
  logic          mem_req_val, mem_req_we;
  logic [AW-1:0] mem_req_addr;
  logic [31:0]   mem_req_wdata;
  logic [3:0]    mem_req_be;
  logic          mem_req_ready = 1'b1;
  logic          mem_rsp_val = 1'b0;
  logic [31:0]   mem_rsp_data = '0;

  mau_resp #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .mau_req_val(mau_req_val), .mau_req_nc(mau_req_nc), .mau_req_we(mau_req_we),
    .mau_req_addr(mau_req_addr), .mau_req_wdata(mau_req_wdata), .mau_req_be(mau_req_be),
    .mau_req_ack(mau_req_ack), .mau_ack_nc(mau_ack_nc), .mau_ack_we(mau_ack_we),
    .mau_ack_data(mau_ack_data),
    .mem_req_val(mem_req_val), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be), .mem_req_ready(mem_req_ready),
    .mem_rsp_val(mem_rsp_val), .mem_rsp_data(mem_rsp_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; } beat_t;
  typedef struct { logic nc; logic we; logic [LW-1:0] data; } ack_t;
  typedef struct { int due; logic [31:0] data; } rsp_t;

  beat_t exp_beats[$];
  ack_t  exp_acks[$];
  rsp_t  rq[$];
  int    checks = 0, failures = 0;
  int    cyc = 0, last_rsp_cyc = -10, wr_acc_cyc = -10, rsp_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h20) ? 32'hDEADBEEF : (32'hD000_0000 | (a & 32'h0FFF_FFFF));
  endfunction

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected memory beats and ack derived from the request itself.
  task automatic push_exp(input logic nc, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
    ack_t e;
    logic [31:0] ba;
    e.nc = nc; e.we = we; e.data = '0;
    if (we) begin
      exp_beats.push_back('{1'b1, a, wd, be});
    end else if (nc) begin
      exp_beats.push_back('{1'b0, a, 32'h0, 4'hF});
      e.data[LW-1 -: 32] = mem_word(a);
    end else begin
      for (int k = 0; k < LW/32; k++) begin
        ba = (a & ~32'(LW/8 - 1)) + 32'(4*k);
        exp_beats.push_back('{1'b0, ba, 32'h0, 4'hF});
        e.data[32*k +: 32] = mem_word(ba);
      end
    end
    exp_acks.push_back(e);
  endtask

  // Present a request, wait (bounded) for its ack; optionally keep val high.
  task automatic req(input logic nc, input logic we, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] be, input bit hold);
    bit got;
    push_exp(nc, we, a, wd, be);
    mau_req_nc = nc; mau_req_we = we; mau_req_addr = a;
    mau_req_wdata = wd; mau_req_be = be; mau_req_val = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #2;
      if (mau_req_ack) got = 1'b1;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL req_timeout addr=%h got=no_ack want=ack", a);
    end
    if (!hold) mau_req_val = 1'b0;
  endtask

  // Memory model and per-cycle compare against the expectation queues.
  always @(negedge clk) begin
    beat_t b;
    ack_t  e;
    #1;
    if (!rst_n) begin
      rq.delete();
      mem_rsp_val = 1'b0;
    end else begin
      if (mem_req_val && mem_req_ready) begin
        if (exp_beats.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_beat got=%h want=none", mem_req_addr);
        end else begin
          b = exp_beats.pop_front();
          chk("beat_we", LW'(mem_req_we), LW'(b.we));
          chk("beat_addr", LW'(mem_req_addr), LW'(b.addr));
          chk("beat_be", LW'(mem_req_be), LW'(b.be));
          if (b.we) begin
            chk("beat_wdata", LW'(mem_req_wdata), LW'(b.wdata));
            wr_acc_cyc = cyc;
          end
        end
        if (!mem_req_we) rq.push_back('{cyc + 2, mem_word(mem_req_addr)});
      end
      if (rq.size() > 0 && rq[0].due == cyc) begin
        mem_rsp_val  = 1'b1;
        mem_rsp_data = rq[0].data;
        void'(rq.pop_front());
        last_rsp_cyc = cyc;
        rsp_seen++;
      end else begin
        mem_rsp_val  = 1'b0;
        mem_rsp_data = '0;
      end
      if (mau_req_ack) begin
        if (exp_acks.size() == 0) begin
          checks++; failures++;
          $display("FAIL extra_ack got=ack want=none (cycle %0d)", cyc);
        end else begin
          e = exp_acks.pop_front();
          chk("ack_nc", LW'(mau_ack_nc), LW'(e.nc));
          chk("ack_we", LW'(mau_ack_we), LW'(e.we));
          if (!e.we) begin
            chk("ack_data", mau_ack_data, e.data);
            chk("rd_ack_lat", LW'(cyc), LW'(last_rsp_cyc + 1));
          end
`ifndef MAU_RESP_POSTED_WR_EN
          if (e.we) chk("wr_ack_lat", LW'(cyc), LW'(wr_acc_cyc + 1));
`endif
        end
      end
    end
  end

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ack"}, LW'(mau_req_ack), '0);
    chk({tag, "_nc"}, LW'(mau_ack_nc), '0);
    chk({tag, "_we"}, LW'(mau_ack_we), '0);
    chk({tag, "_data"}, mau_ack_data, '0);
    chk({tag, "_memval"}, LW'(mem_req_val), '0);
  endtask

  initial begin
    bit ok;
    @(posedge clk); #2;
    chk_reset_outs("rst0");
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Line fill at unaligned address: reads 0x100..0x10C, words in ascending slots.
    req(1'b0, 1'b0, 32'h104, 32'h0, 4'h0, 1'b0);
    chk("fill104_lit", mau_ack_data, 128'hD000010C_D0000108_D0000104_D0000100);

    // NC read: word at the top of the line, rest zero.
    req(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
    chk("nc20_lit", mau_ack_data, {32'hDEADBEEF, 96'h0});
    chk("nc20_ncflag", LW'(mau_ack_nc), LW'(1));

    // Write with memory stalling for a few cycles.
    mem_req_ready = 1'b0;
    fork
      begin repeat (4) @(posedge clk); #2; mem_req_ready = 1'b1; end
    join_none
    req(1'b0, 1'b1, 32'h40, 32'h11223344, 4'b0011, 1'b0);
    chk("wr40_weflag", LW'(mau_ack_we), LW'(1));
    repeat (6) @(posedge clk); #2;

    // Back-to-back with val held through ack: fill -> NC read -> write.
    req(1'b0, 1'b0, 32'h1F8, 32'h0, 4'h0, 1'b1);
    fork
      req(1'b1, 1'b0, 32'h80, 32'h0, 4'h0, 1'b1);
      begin
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("b2b_issue", {mem_req_val, mem_req_we, mem_req_addr},
            {1'b1, 1'b0, 32'h80});
      end
    join
    req(1'b0, 1'b1, 32'h90, 32'hCAFEF00D, 4'hF, 1'b0);
    repeat (4) @(posedge clk); #2;

    // Reset after two fill responses, then a clean fill.
    req(1'b0, 1'b1, 32'h60, 32'h55AA55AA, 4'hF, 1'b0);
    repeat (4) @(posedge clk); #2;
    begin
      int base;
      base = rsp_seen;
      push_exp(1'b0, 1'b0, 32'h200, 32'h0, 4'h0);
      mau_req_nc = 1'b0; mau_req_we = 1'b0; mau_req_addr = 32'h200; mau_req_val = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
        @(posedge clk); #2;
        if (rsp_seen >= base + 2) ok = 1'b1;
      end
      if (!ok) begin
        checks++; failures++;
        $display("FAIL rst_wait got=%0d want=%0d", rsp_seen - base, 2);
      end
      mau_req_val = 1'b0;
      rst_n = 1'b0;
      exp_acks.delete();
      exp_beats.delete();
      #1;
      chk_reset_outs("rst_mid");
      @(posedge clk); #2;
      chk_reset_outs("rst_hold");
      rst_n = 1'b1;
      @(posedge clk); #2;
    end
    req(1'b0, 1'b0, 32'h300, 32'h0, 4'h0, 1'b0);
    chk("fill300_lit", mau_ack_data, 128'hD000030C_D0000308_D0000304_D0000300);

    repeat (10) @(posedge clk); #2;
    chk("acks_drained", LW'(exp_acks.size()), '0);
    chk("beats_drained", LW'(exp_beats.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
